// File: rtl/i2c_slave_receiver.sv
// I2C slave endpoint: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// write bytes to a strobed RX port, read bytes from a strobed TX port; SDA is open-drain.
`timescale 1ns/1ps

module i2c_slave_receiver #(
    parameter int unsigned DataWidth    = 8,
    parameter logic [6:0]  SlaveAddress = 7'h1A,
    parameter int unsigned SyncStages   = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic                 SCL,
    input  logic                 SDA_IN,
    output logic                 SDA_DRIVE_LOW,
    output logic [DataWidth-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic [DataWidth-1:0] TX_DATA,
    output logic                 TX_REQ,
    output logic                 ADDR_MATCH,
    output logic                 R_NW,
    output logic                 START_DET,
    output logic                 STOP_DET
);

    localparam int unsigned CntW = $clog2(DataWidth + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX_BYTE,
        S_RX_ACK,
        S_TX_BYTE,
        S_TX_ACK,
        S_IGNORE
    } state_e;

    logic [SyncStages-1:0] scl_sync_q;
    logic [SyncStages-1:0] sda_sync_q;
    logic                  scl_prev_q;
    logic                  sda_prev_q;

    state_e                state_q;
    logic [CntW-1:0]       bit_cnt_q;
    logic [DataWidth-1:0]  shift_q;
    logic                  master_nack_q;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_c;
    logic stop_c;
    logic byte_done;

    // Synchronisers idle high so a freshly reset block sees a quiet bus.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SyncStages-2:0], SCL};
            sda_sync_q <= {sda_sync_q[SyncStages-2:0], SDA_IN};
            scl_prev_q <= scl_sync_q[SyncStages-1];
            sda_prev_q <= sda_sync_q[SyncStages-1];
        end
    end

    assign scl_s     = scl_sync_q[SyncStages-1];
    assign sda_s     = sda_sync_q[SyncStages-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // An SDA edge only counts as START/STOP when SCL is steadily high across the sample.
    assign start_c   = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c    = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign byte_done = (bit_cnt_q == CntW'(DataWidth));

    always_ff @(posedge CLK) begin
        if (RESET || !ENABLE) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            master_nack_q <= 1'b0;
            SDA_DRIVE_LOW <= 1'b0;
            RX_DATA       <= '0;
            RX_VALID      <= 1'b0;
            TX_REQ        <= 1'b0;
            ADDR_MATCH    <= 1'b0;
            R_NW          <= 1'b0;
            START_DET     <= 1'b0;
            STOP_DET      <= 1'b0;
        end else begin
            RX_VALID  <= 1'b0;
            TX_REQ    <= 1'b0;
            START_DET <= 1'b0;
            STOP_DET  <= 1'b0;

            if (start_c) begin
                state_q       <= S_ADDR;
                bit_cnt_q     <= '0;
                SDA_DRIVE_LOW <= 1'b0;
                ADDR_MATCH    <= 1'b0;
                START_DET     <= 1'b1;
            end else if (stop_c) begin
                state_q       <= S_IDLE;
                bit_cnt_q     <= '0;
                SDA_DRIVE_LOW <= 1'b0;
                ADDR_MATCH    <= 1'b0;
                STOP_DET      <= 1'b1;
            end else begin
                case (state_q)
                    S_ADDR: begin
                        if (scl_rise && !byte_done) begin
                            shift_q   <= {shift_q[DataWidth-2:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                        end else if (scl_fall && byte_done) begin
                            bit_cnt_q <= '0;
                            if (shift_q[DataWidth-1 -: 7] == SlaveAddress) begin
                                state_q       <= S_ADDR_ACK;
                                SDA_DRIVE_LOW <= 1'b1;
                                ADDR_MATCH    <= 1'b1;
                                R_NW          <= shift_q[0];
                            end else begin
                                state_q <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= '0;
                            if (R_NW) begin
                                state_q       <= S_TX_BYTE;
                                TX_REQ        <= 1'b1;
                                shift_q       <= TX_DATA;
                                SDA_DRIVE_LOW <= ~TX_DATA[DataWidth-1];
                            end else begin
                                state_q       <= S_RX_BYTE;
                                SDA_DRIVE_LOW <= 1'b0;
                            end
                        end
                    end
                    S_RX_BYTE: begin
                        if (scl_rise && !byte_done) begin
                            shift_q   <= {shift_q[DataWidth-2:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                        end else if (scl_fall && byte_done) begin
                            bit_cnt_q     <= '0;
                            RX_DATA       <= shift_q;
                            RX_VALID      <= 1'b1;
                            SDA_DRIVE_LOW <= 1'b1;
                            state_q       <= S_RX_ACK;
                        end
                    end
                    S_RX_ACK: begin
                        if (scl_fall) begin
                            SDA_DRIVE_LOW <= 1'b0;
                            state_q       <= S_RX_BYTE;
                        end
                    end
                    // MSB went out on entry; each later falling edge presents the next bit.
                    S_TX_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == CntW'(DataWidth - 1)) begin
                                bit_cnt_q     <= '0;
                                SDA_DRIVE_LOW <= 1'b0;
                                master_nack_q <= 1'b1;
                                state_q       <= S_TX_ACK;
                            end else begin
                                bit_cnt_q     <= bit_cnt_q + CntW'(1);
                                SDA_DRIVE_LOW <= ~shift_q[DataWidth-2];
                                shift_q       <= {shift_q[DataWidth-2:0], 1'b0};
                            end
                        end
                    end
                    S_TX_ACK: begin
                        if (scl_rise) begin
                            master_nack_q <= sda_s;
                        end else if (scl_fall) begin
                            if (!master_nack_q) begin
                                state_q       <= S_TX_BYTE;
                                TX_REQ        <= 1'b1;
                                shift_q       <= TX_DATA;
                                SDA_DRIVE_LOW <= ~TX_DATA[DataWidth-1];
                            end else begin
                                state_q       <= S_IGNORE;
                                SDA_DRIVE_LOW <= 1'b0;
                            end
                        end
                    end
                    S_IGNORE: begin
                        SDA_DRIVE_LOW <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
